dds_ctrl: RTL and testbench
===========================

# dds_ctrl

Sequencer for the 16-bit pipelined CORDIC sine generator. It loads the 64-entry × 48-bit coefficient table through the generator's write port, then enables the pipeline. While running it applies frequency/offset retunes, and it drains the pipeline on stop. It sits between the host/register interface and the generator's `cen`/`wen`/`index_wri`/`D`/`fcw`/`offset` inputs.

## Interface
- `DEPTH`, 64: coefficient table entries.
- `AW`, 6: table index width; DEPTH = 2^AW.
- `DW`, 48: coefficient word width.
- `FW`, 16: fcw/offset width.
- `PIPE_LAT`, 8: drain cycles after `cen` drops.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse; begin table load (honoured in IDLE only).
- `ld_valid`  in  1  coefficient word valid.
- `ld_data`  in  DW  coefficient word, entries in ascending index order.
- `ld_ready`  out  1  coefficient word accepted when valid&ready.
- `run_req`  in  1  level; 1 = run generator, 0 = stop.
- `freq_valid`  in  1  retune request.
- `freq_fcw`  in  FW  new frequency control word.
- `freq_off`  in  FW  new phase offset.
- `freq_ready`  out  1  retune accepted when valid&ready.
- `wen`  out  1  table write strobe to generator.
- `index_wri`  out  AW  table write index.
- `D`  out  DW  table write data.
- `cen`  out  1  generator pipeline enable.
- `fcw`  out  FW  registered frequency word.
- `offset`  out  FW  registered phase offset.
- `loaded`  out  1  table holds a complete image.
- `running`  out  1  state is RUN.
- `busy`  out  1  state is LOAD or DRAIN.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- **IDLE**
  - `load_start` → LOAD; clears `loaded`; resets the write index to 0.
  - `run_req`=1 with `loaded`=1 → RUN.
  - `run_req` without `loaded` is ignored.
  - `load_start` has priority over `run_req`.
- **LOAD**
  - `ld_ready`=1.
  - Each accepted word drives `wen`=1, `D`=`ld_data` and `index_wri`=current index in the next cycle, then the index increments.
  - Accepting the word at index DEPTH-1 sets `loaded` and returns to IDLE.
  - `load_start` and `run_req` are ignored in LOAD.
- **RUN**
  - `cen`=1.
  - `run_req`=0 → DRAIN.
  - `load_start` is ignored in RUN.
- **DRAIN**
  - `cen`=0.
  - A counter counts PIPE_LAT cycles, then the block returns to IDLE.
  - `run_req` rising during DRAIN does not abort the drain; it is re-sampled in IDLE.
- **Retune**
  - `freq_ready`=1 in IDLE and RUN, 0 in LOAD and DRAIN.
  - An accepted request loads `fcw`/`offset` together in the next cycle, so the two never update separately.
- `wen` is 0 in every state except the LOAD write cycle.
- The write index wraps modulo 2^AW. It is only reused after a new `load_start`.

## Timing
- Reset values (asynchronous, while `reset`=0): state IDLE, `wen`=0, `index_wri`=0, `D`=0, `cen`=0, `fcw`=0, `offset`=0, `loaded`=0, `running`=0, `busy`=0, `ld_ready`=0, `freq_ready`=0. The drain counter is 0.
- Reset mid-LOAD leaves `loaded`=0; the host must reload.
- Reset mid-RUN drops `cen` immediately, without a drain.
- All outputs are registered.
- Latencies:
  - Handshake to `wen`/`D`: 1 cycle.
  - Retune handshake to `fcw`/`offset`: 1 cycle.
  - `run_req`=1 in IDLE to `cen`=1: 1 cycle.
  - `run_req`=0 to `cen`=0: 1 cycle.
  - DRAIN to IDLE: exactly PIPE_LAT cycles.
- Back-to-back: one coefficient word per cycle sustained; a full load takes DEPTH cycles with `ld_valid` held high.

## Configuration
- `DDS_CTRL_CKSUM_EN`
  - Defined:
    - Adds input port `ld_cksum` [DW-1:0], sampled at the final load handshake.
    - Adds output port `cksum_err`.
    - The block XOR-accumulates all accepted words.
    - A mismatch sets `cksum_err`=1 and leaves `loaded`=0, which blocks RUN.
    - `cksum_err` clears on the next `load_start`.
  - Undefined: neither port exists, and `loaded` is set unconditionally at the end of the load.

## Structure
- Shared package `dds_pkg`:
  - State enum `dds_ctrl_state_t`: IDLE, LOAD, RUN, DRAIN.
  - Defaults for DEPTH, AW, DW, FW, PIPE_LAT.
- The FSM, index counter and retune registers stay in `dds_ctrl`.
- One sub-module, `dds_drain_cnt`, holds the PIPE_LAT down-counter with load/done.

## Test plan
- Reset, then `load_start` and 64 words `ld_data`=i×3 with `ld_valid` held → `wen` high for 64 consecutive cycles, `index_wri` 0..63, `D`=i×3, `loaded`=1 one cycle after the last handshake.
- Load with `ld_valid` toggled 1/0 → only valid cycles write, indices stay contiguous, the load completes after 64 accepted words.
- `run_req`=1 before any load → `cen` stays 0. After a load, `run_req`=1 → `cen`=1 next cycle. `run_req`=0 → `cen`=0 next cycle and `busy`=1 for exactly 8 cycles.
- In RUN, retune with fcw=0x1234, off=0x0800 → both outputs change on the same cycle, one cycle after the handshake. During DRAIN, `freq_ready`=0.
- `reset` asserted at load word 30 → all outputs are 0 immediately. A subsequent `run_req` leaves `cen`=0.
- With `DDS_CTRL_CKSUM_EN` defined, a wrong `ld_cksum` → `cksum_err`=1, `loaded`=0 and `run_req` ignored. A correct `ld_cksum` → `cksum_err`=0 and `loaded`=1.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sequencer: default table/word geometry,
// pipeline drain latency and the sequencer state encoding.
package dds_pkg;

  localparam int DDS_DEPTH    = 64;  // coefficient table entries
  localparam int DDS_AW       = 6;   // table index width, DEPTH = 2**AW
  localparam int DDS_DW       = 48;  // coefficient word width
  localparam int DDS_FW       = 16;  // fcw / offset width
  localparam int DDS_PIPE_LAT = 8;   // CORDIC pipeline drain cycles

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } dds_ctrl_state_t;

endpackage

// File: rtl/dds_drain_cnt.sv
// Pipeline drain down-counter. A load pulse presets the count; while enabled
// it counts down to zero and holds there. done is high at zero.
module dds_drain_cnt #(
  parameter int W        = 4,
  parameter int LOAD_VAL = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt;

  // Preset on load, otherwise decrement while enabled and not yet at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dds_ctrl.sv
// Sequencer for the pipelined CORDIC sine generator: loads the coefficient
// table, enables the pipeline, applies fcw/offset retunes and drains the
// pipeline on stop. Every output is a flop.
// Optional build macro DDS_CTRL_CKSUM_EN adds an XOR checksum over the
// loaded image (ports ld_cksum / cksum_err); a mismatch keeps loaded low.
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int DEPTH    = DDS_DEPTH,
  parameter int AW       = DDS_AW,
  parameter int DW       = DDS_DW,
  parameter int FW       = DDS_FW,
  parameter int PIPE_LAT = DDS_PIPE_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          run_req,
  input  logic          freq_valid,
  input  logic [FW-1:0] freq_fcw,
  input  logic [FW-1:0] freq_off,
  output logic          freq_ready,
  output logic          wen,
  output logic [AW-1:0] index_wri,
  output logic [DW-1:0] D,
  output logic          cen,
  output logic [FW-1:0] fcw,
  output logic [FW-1:0] offset,
  output logic          loaded,
  output logic          running,
`ifdef DDS_CTRL_CKSUM_EN
  input  logic [DW-1:0] ld_cksum,
  output logic          cksum_err,
`endif
  output logic          busy
);

  localparam int CW = $clog2(PIPE_LAT) + 1;

  dds_ctrl_state_t state;
  logic [AW-1:0]   wr_idx;
  logic            drain_load;
  logic            drain_done;
  logic            ld_fire;
  logic            last_word;
`ifdef DDS_CTRL_CKSUM_EN
  logic [DW-1:0]   cksum_acc;
`endif

  assign ld_fire    = ld_valid && ld_ready;
  assign last_word  = (wr_idx == AW'(DEPTH - 1));
  assign drain_load = (state == RUN) && !run_req;

  // Drain counter preset to PIPE_LAT-1 on entry so DRAIN lasts PIPE_LAT cycles.
  dds_drain_cnt #(
    .W        (CW),
    .LOAD_VAL (PIPE_LAT - 1)
  ) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (drain_load),
    .en    (state == DRAIN),
    .done  (drain_done)
  );

  // Sequencer FSM; status outputs are registered from the next state so they
  // line up with the state they describe.
  // NOTE: non-blocking (<=) throughout so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_idx     <= '0;
      wen        <= 1'b0;
      index_wri  <= '0;
      D          <= '0;
      cen        <= 1'b0;
      fcw        <= '0;
      offset     <= '0;
      loaded     <= 1'b0;
      running    <= 1'b0;
      busy       <= 1'b0;
      ld_ready   <= 1'b0;
      freq_ready <= 1'b0;
`ifdef DDS_CTRL_CKSUM_EN
      cksum_acc  <= '0;
      cksum_err  <= 1'b0;
`endif
    end else begin
      wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            loaded     <= 1'b0;
            wr_idx     <= '0;
            ld_ready   <= 1'b1;
            busy       <= 1'b1;
            freq_ready <= 1'b0;
`ifdef DDS_CTRL_CKSUM_EN
            cksum_acc  <= '0;
            cksum_err  <= 1'b0;
`endif
          end else if (run_req && loaded) begin
            state      <= RUN;
            cen        <= 1'b1;
            running    <= 1'b1;
            freq_ready <= 1'b1;
          end else begin
            freq_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            wen       <= 1'b1;
            D         <= ld_data;
            index_wri <= wr_idx;
            wr_idx    <= wr_idx + 1'b1;
`ifdef DDS_CTRL_CKSUM_EN
            cksum_acc <= cksum_acc ^ ld_data;
`endif
            if (last_word) begin
              state      <= IDLE;
              ld_ready   <= 1'b0;
              busy       <= 1'b0;
              freq_ready <= 1'b1;
`ifdef DDS_CTRL_CKSUM_EN
              if ((cksum_acc ^ ld_data) == ld_cksum) begin
                loaded <= 1'b1;
              end else begin
                cksum_err <= 1'b1;
              end
`else
              loaded     <= 1'b1;
`endif
            end
          end
        end
        RUN: begin
          if (!run_req) begin
            state      <= DRAIN;
            cen        <= 1'b0;
            running    <= 1'b0;
            busy       <= 1'b1;
            freq_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            freq_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // fcw and offset share one enable so the generator never sees a half retune.
      if (freq_valid && freq_ready) begin
        fcw    <= freq_fcw;
        offset <= freq_off;
      end
    end
  end

endmodule

// File: tb/tb_dds_ctrl.sv
// Self-checking bench for dds_ctrl. Inputs change and outputs are sampled on
// the falling clock edge; the expected table writes, flags and tuning words
// come from a small reference model of the sequencer's externally visible
// behaviour.
module tb_dds_ctrl;
  import dds_pkg::*;

  localparam int DEPTH    = DDS_DEPTH;
  localparam int AW       = DDS_AW;
  localparam int DW       = DDS_DW;
  localparam int FW       = DDS_FW;
  localparam int PIPE_LAT = DDS_PIPE_LAT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          run_req = 1'b0;
  logic          freq_valid = 1'b0;
  logic [FW-1:0] freq_fcw = '0;
  logic [FW-1:0] freq_off = '0;
  logic          freq_ready;
  logic          wen;
  logic [AW-1:0] index_wri;
  logic [DW-1:0] D;
  logic          cen;
  logic [FW-1:0] fcw;
  logic [FW-1:0] offset;
  logic          loaded;
  logic          running;
  logic          busy;
`ifdef DDS_CTRL_CKSUM_EN
  logic [DW-1:0] ld_cksum = '0;
  logic          cksum_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [FW-1:0] m_fcw = '0;
  logic [FW-1:0] m_off = '0;
  bit            m_loaded = 1'b0;

  always #5 clk = ~clk;

  dds_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .run_req    (run_req),
    .freq_valid (freq_valid),
    .freq_fcw   (freq_fcw),
    .freq_off   (freq_off),
    .freq_ready (freq_ready),
    .wen        (wen),
    .index_wri  (index_wri),
    .D          (D),
    .cen        (cen),
    .fcw        (fcw),
    .offset     (offset),
    .loaded     (loaded),
    .running    (running),
`ifdef DDS_CTRL_CKSUM_EN
    .ld_cksum   (ld_cksum),
    .cksum_err  (cksum_err),
`endif
    .busy       (busy)
  );

  // Full load sequence; stop_at < DEPTH abandons the load after that many words.
  task automatic do_load(input bit gapped, input bit ramp, input bit bad_ck,
                         input int stop_at, input bit hold_run);
    logic [DW-1:0] words [DEPTH];
    logic [DW-1:0] xsum;
    int idx;
    int cyc;
    xsum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = ramp ? DW'(i * 3) : DW'({$urandom(), $urandom()});
      xsum     = xsum ^ words[i];
    end
`ifdef DDS_CTRL_CKSUM_EN
    ld_cksum = bad_ck ? (xsum ^ DW'(1)) : xsum;
`endif
    run_req    = hold_run;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++;
    if ({ld_ready, busy, loaded, cen, wen} !== 5'b11000)
      $display("FAIL load_enter: ready/busy/loaded/cen/wen got %b want 11000",
               {ld_ready, busy, loaded, cen, wen});
`ifdef DDS_CTRL_CKSUM_EN
    checks++;
    if (cksum_err !== 1'b0) begin
      errors++;
      $display("FAIL cksum_clear: cksum_err got %b want 0", cksum_err);
    end
`endif
    if ({ld_ready, busy, loaded, cen, wen} !== 5'b11000) errors++;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 2000) begin
      ld_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = ld_valid ? words[idx] : DW'({$urandom(), $urandom()});
      @(negedge clk);
      checks++;
      if (ld_valid) begin
        if ({wen, index_wri, D} !== {1'b1, AW'(idx), words[idx]}) begin
          errors++;
          $display("FAIL load_write: wen/idx/D got %b/%0d/%h want 1/%0d/%h",
                   wen, index_wri, D, idx, words[idx]);
        end
        idx++;
      end else if (wen !== 1'b0) begin
        errors++;
        $display("FAIL load_idle_cycle: wen got %b want 0", wen);
      end
      if (idx < DEPTH) begin
        checks++;
        if ({ld_ready, busy, cen, loaded} !== 4'b1100) begin
          errors++;
          $display("FAIL load_status: ready/busy/cen/loaded got %b want 1100",
                   {ld_ready, busy, cen, loaded});
        end
      end
      cyc++;
    end
    ld_valid = 1'b0;
    run_req  = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d words want %0d", idx, stop_at);
    end
    if (stop_at < DEPTH) return;
`ifdef DDS_CTRL_CKSUM_EN
    m_loaded = !bad_ck;
    checks++;
    if (cksum_err !== bad_ck) begin
      errors++;
      $display("FAIL cksum_err: got %b want %b", cksum_err, bad_ck);
    end
`else
    m_loaded = 1'b1;
`endif
    checks++;
    if ({loaded, busy, ld_ready, cen} !== {m_loaded, 3'b000}) begin
      errors++;
      $display("FAIL load_done: loaded/busy/ready/cen got %b want %b000",
               {loaded, busy, ld_ready, cen}, m_loaded);
    end
    @(negedge clk);
    checks++;
    if ({wen, cen, ld_ready} !== 3'b000) begin
      errors++;
      $display("FAIL load_after: wen/cen/ready got %b want 000", {wen, cen, ld_ready});
    end
  endtask

  // One retune attempt; the model commits the new words only when accepted.
  task automatic do_retune(input logic [FW-1:0] f, input logic [FW-1:0] o,
                           input bit exp_ready);
    checks++;
    if ({freq_ready, fcw, offset} !== {exp_ready, m_fcw, m_off}) begin
      errors++;
      $display("FAIL retune_pre: ready/fcw/off got %b/%h/%h want %b/%h/%h",
               freq_ready, fcw, offset, exp_ready, m_fcw, m_off);
    end
    freq_valid = 1'b1;
    freq_fcw   = f;
    freq_off   = o;
    @(negedge clk);
    freq_valid = 1'b0;
    if (exp_ready) begin
      m_fcw = f;
      m_off = o;
    end
    checks++;
    if ({fcw, offset} !== {m_fcw, m_off}) begin
      errors++;
      $display("FAIL retune_post: fcw/off got %h/%h want %h/%h", fcw, offset, m_fcw, m_off);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({wen, index_wri, D, cen, fcw, offset, loaded, running, busy, ld_ready, freq_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: outputs not all zero (wen=%b idx=%0d D=%h cen=%b fcw=%h off=%h)",
               wen, index_wri, D, cen, fcw, offset);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({cen, busy, ld_ready, freq_ready, loaded} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_held: cen/busy/ready/fready/loaded got %b want 00000",
               {cen, busy, ld_ready, freq_ready, loaded});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({freq_ready, ld_ready, busy, loaded} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: fready/ready/busy/loaded got %b want 1000",
               {freq_ready, ld_ready, busy, loaded});
    end
  endtask

  task automatic test_run_without_load();
    run_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({cen, running, busy} !== 3'b000) begin
        errors++;
        $display("FAIL run_unloaded: cen/running/busy got %b want 000", {cen, running, busy});
      end
    end
    run_req = 1'b0;
  endtask

  task automatic test_load_burst();
    do_load(1'b0, 1'b1, 1'b0, DEPTH, 1'b0);
  endtask

  task automatic test_load_gapped();
    // run_req held high with a loaded table: load_start must still win.
    do_load(1'b1, 1'b0, 1'b0, DEPTH, 1'b1);
  endtask

  task automatic test_retune_idle();
    repeat (3) do_retune(FW'($urandom()), FW'($urandom()), 1'b1);
  endtask

  task automatic test_run_drain();
    int busy_cycles;
    int guard;
    run_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({cen, running, busy} !== 3'b110) begin
      errors++;
      $display("FAIL run_start: cen/running/busy got %b want 110", {cen, running, busy});
    end
    do_retune(16'h1234, 16'h0800, 1'b1);
    repeat (3) do_retune(FW'($urandom()), FW'($urandom()), 1'b1);
    run_req = 1'b0;
    @(negedge clk);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 4 * PIPE_LAT) begin
      checks++;
      if ({cen, running, freq_ready, fcw, offset} !== {3'b000, m_fcw, m_off}) begin
        errors++;
        $display("FAIL drain_status: cen/run/fready got %b fcw/off %h/%h want 000 %h/%h",
                 {cen, running, freq_ready}, fcw, offset, m_fcw, m_off);
      end
      freq_valid = 1'b1;
      freq_fcw   = FW'($urandom());
      freq_off   = FW'($urandom());
      if (busy_cycles == 2) run_req = 1'b1;
      busy_cycles++;
      @(negedge clk);
    end
    freq_valid = 1'b0;
    checks++;
    if (busy_cycles != PIPE_LAT) begin
      errors++;
      $display("FAIL drain_length: busy cycles got %0d want %0d", busy_cycles, PIPE_LAT);
    end
    checks++;
    if ({cen, fcw, offset} !== {1'b0, m_fcw, m_off}) begin
      errors++;
      $display("FAIL drain_exit: cen/fcw/off got %b/%h/%h want 0/%h/%h",
               cen, fcw, offset, m_fcw, m_off);
    end
    @(negedge clk);
    checks++;
    if ({cen, running} !== 2'b11) begin
      errors++;
      $display("FAIL rerun_after_drain: cen/running got %b want 11", {cen, running});
    end
    run_req = 1'b0;
    guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 4 * PIPE_LAT) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if ({busy, cen, freq_ready} !== 3'b001) begin
      errors++;
      $display("FAIL drain2_exit: busy/cen/fready got %b want 001", {busy, cen, freq_ready});
    end
  endtask

  task automatic test_reset_mid_load();
    do_load(1'b0, 1'b0, 1'b0, 30, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if ({wen, index_wri, D, cen, fcw, offset, loaded, running, busy, ld_ready, freq_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: outputs not all zero (wen=%b idx=%0d busy=%b ready=%b)",
               wen, index_wri, busy, ld_ready);
    end
    @(negedge clk);
    reset    = 1'b1;
    m_loaded = 1'b0;
    m_fcw    = '0;
    m_off    = '0;
    run_req  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({cen, running, loaded} !== 3'b000) begin
        errors++;
        $display("FAIL run_after_reset: cen/running/loaded got %b want 000", {cen, running, loaded});
      end
    end
    run_req = 1'b0;
  endtask

`ifdef DDS_CTRL_CKSUM_EN
  task automatic test_cksum();
    do_load(1'b0, 1'b0, 1'b1, DEPTH, 1'b0);
    run_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({cen, loaded} !== 2'b00) begin
        errors++;
        $display("FAIL cksum_blocks_run: cen/loaded got %b want 00", {cen, loaded});
      end
    end
    run_req = 1'b0;
    do_load(1'b1, 1'b0, 1'b0, DEPTH, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_run_without_load();
    test_load_burst();
    test_run_drain();
    test_retune_idle();
    test_load_gapped();
    test_run_drain();
    test_reset_mid_load();
`ifdef DDS_CTRL_CKSUM_EN
    test_cksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
